// File: rtl/output_write_ctrl.sv
// Output-memory write sequencer: round-robin arbitrates two valid/ready result
// producers and writes accepted words to consecutive addresses from base_addr.
module output_write_ctrl #(
   parameter int AW    = 6,
   parameter int DW    = 32,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    base_addr,
   input  logic [CNT_W-1:0] num_words,
   input  logic             req0_valid,
   input  logic [DW-1:0]    req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [DW-1:0]    req1_data,
   output logic             req1_ready,
   output logic             mem_en,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] words_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(2 ** AW);

   logic [1:0]       state;
   logic [AW-1:0]    wr_ptr;
   logic [CNT_W-1:0] num_lat;
   logic             rr_last;      // index of the producer granted most recently
   logic [CNT_W-1:0] num_clamped;
   logic             accept;
   logic             last_word;
   logic [DW-1:0]    acc_data;

   // NOTE: every signal driven from always_comb gets a default first so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (state == S_RUN) begin
         req0_ready = req0_valid & (~req1_valid | rr_last);
         req1_ready = req1_valid & (~req0_valid | ~rr_last);
      end
   end

   always_comb begin
      num_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
      accept      = req0_ready | req1_ready;
      acc_data    = req1_ready ? req1_data : req0_data;
      last_word   = accept && ((words_done + CNT_W'(1)) == num_lat);
   end

   assign busy = (state == S_RUN);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         num_lat    <= '0;
         rr_last    <= 1'b1;
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         done       <= 1'b0;
         words_done <= '0;
      end else begin
         mem_en <= accept;
         done   <= 1'b0;
         if (accept) begin
            mem_addr   <= wr_ptr;
            mem_wdata  <= acc_data;
            wr_ptr     <= wr_ptr + AW'(1);
            words_done <= words_done + CNT_W'(1);
            rr_last    <= req1_ready;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  words_done <= '0;
                  if (num_clamped == '0) begin
                     // Empty job completes without ever entering RUN.
                     done <= 1'b1;
                  end else begin
                     state   <= S_RUN;
                     num_lat <= num_clamped;
                     wr_ptr  <= base_addr;
                  end
               end
            end
            S_RUN: begin
               if (last_word) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_output_write_ctrl.sv
// Randomized and directed bench for output_write_ctrl, checked cycle by cycle
// against a job-level reference model (expected writes, grants, done, counts).
module tb_output_write_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  base_addr;
   logic [6:0]  num_words;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        mem_en;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        busy, done;
   logic [6:0]  words_done;

   int errors = 0;
   int checks = 0;

   // Reference model: job progress, not hardware state.
   bit          m_active, m_closing;
   int          m_total, m_cnt, m_ptr, m_last;
   bit          e_en, e_done;
   logic [5:0]  e_addr;
   logic [31:0] e_data;

   output_write_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_words(num_words),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .words_done(words_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_closing = 0; m_total = 0; m_cnt = 0; m_ptr = 0;
      m_last = 1; e_en = 0; e_done = 0; e_addr = '0; e_data = '0;
   endtask

   task automatic cycle(input bit r, input bit st, input int ba, input int nw,
                        input bit v0, input bit v1);
      int          g, n;
      bit          was_active, next_closing;
      logic [31:0] d0, d1;
      d0 = $urandom;
      d1 = $urandom;
      @(negedge clk);
      rst = r; start = st; base_addr = ba[5:0]; num_words = nw[6:0];
      req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
      #1;
      if (r) begin
         model_reset();
      end else begin
         g = -1;
         if (m_active) begin
            if (v0 && v1) g = 1 - m_last;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
         end
         check("req0_ready", req0_ready, g == 0);
         check("req1_ready", req1_ready, g == 1);
         was_active   = m_active;
         next_closing = 0;
         e_en   = (g >= 0);
         e_done = 0;
         if (g >= 0) begin
            e_addr = m_ptr[5:0];
            e_data = (g == 1) ? d1 : d0;
            m_ptr  = (m_ptr + 1) % 64;
            m_cnt++;
            m_last = g;
            if (m_cnt == m_total) begin
               m_active = 0; e_done = 1; next_closing = 1;
            end
         end
         if (!was_active && !m_closing && st) begin
            n = (nw > 64) ? 64 : nw;
            m_cnt = 0;
            if (n == 0) e_done = 1;
            else begin
               m_active = 1; m_total = n; m_ptr = ba % 64;
            end
         end
         m_closing = next_closing;
      end
      @(posedge clk);
      #1;
      check("mem_en", mem_en, e_en);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_data);
      check("done", done, e_done);
      check("busy", busy, m_active);
      check("words_done", words_done, m_cnt);
   endtask

   initial begin
      rst = 1; start = 0; base_addr = '0; num_words = '0;
      req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
      model_reset();
      cycle(1, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);

      // T1: reset held two cycles in the middle of a job
      cycle(0, 1, 10, 20, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 1);
      cycle(1, 0, 0, 0, 1, 1);
      cycle(1, 0, 0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 1);

      // T2: single producer back-to-back
      cycle(0, 1, 5, 3, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

      // T3: contention, then valids outside a job
      cycle(0, 1, 0, 4, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 1, 1);

      // T4: address wrap
      cycle(0, 1, 62, 4, 0, 0);
      for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 1);

      // T5: zero-length job
      cycle(0, 1, 9, 0, 0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);

      // T6: sparse producer, stray start mid-job, valid after completion
      cycle(0, 1, 20, 2, 0, 0);
      for (int i = 0; i < 12; i++) cycle(0, (i == 3), 40, 5, 0, (i % 3) == 2);

      // Oversized word count is clamped to the full memory
      cycle(0, 1, 3, 100, 0, 0);
      for (int i = 0; i < 70; i++) cycle(0, 0, 0, 0, 1, 0);

      // Start in the done cycle is ignored, start right after is taken
      cycle(0, 1, 7, 1, 0, 0);
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 1, 30, 2, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, (i == 0), 30, 2, 1, 1);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         automatic int nw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 127))
                                                         : int'($urandom_range(0, 8));
         cycle($urandom_range(0, 249) == 0, $urandom_range(0, 7) == 0,
               int'($urandom_range(0, 63)), nw,
               $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
